// File: rtl/z80_int_pkg.sv
// Shared definitions for the Z80 mode-2 interrupt controller.
//   state_e  : controller FSM states
//   REG_*    : register-port addresses
//   MAX_SRC  : widest supported request vector (register width)
package z80_int_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

endpackage

// File: rtl/z80_int_ctrl_prio_enc_lsb.sv
// Combinational lowest-index priority encoder.
//   req   in  WIDTH : request bits
//   valid out 1     : any request bit set
//   idx   out 3     : index of the lowest set bit (0 when none)
module prio_enc_lsb #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [2:0]       idx
);

    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/z80_int_ctrl.sv
// Interrupt controller for the A-Z80 core (mode-2 vectored interrupts).
// Latches rising edges on irq_req, gates them with MASK and GEN, asserts
// nint for the lowest-numbered enabled source and returns the vector
// VEC_BASE | {sel,1'b0} during the M1+IORQ acknowledge cycle.
//   clk, reset           : clock, synchronous active-high reset
//   irq_req[NUM_SRC]     : peripheral requests (rising-edge detected)
//   cfg_we/addr/wdata    : register write port
//   cfg_rdata            : combinational register read data
//   nm1, niorq           : CPU M1 / IORQ, active-low
//   nint                 : CPU interrupt, active-low, registered
//   vector, vector_oe    : acknowledge vector and bus drive enable, registered
module z80_int_ctrl
    import z80_int_pkg::*;
#(
    parameter int         NUM_SRC  = 8,
    parameter logic [7:0] VEC_BASE = 8'hE0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata,
    input  logic               nm1,
    input  logic               niorq,
    output logic               nint,
    output logic [7:0]         vector,
    output logic               vector_oe
);

    // Bits at or above NUM_SRC never hold state and read back as 0.
    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    state_e             state_q, state_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0]         pending_q, pending_d;
    logic               gen_q, gen_d;
    logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [2:0]         sel_q, sel_d;
    logic               nint_q, nint_d;
    logic [7:0]         vector_q, vector_d;
    logic               vector_oe_q, vector_oe_d;

    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic [7:0] enabled;
    logic       ack;
    logic       enc_valid;
    logic [2:0] enc_idx;

    assign ack     = ~nm1 & ~niorq;
    assign enabled = pending_q & mask_q & {MAX_SRC{gen_q}};

    prio_enc_lsb #(.WIDTH(NUM_SRC)) u_prio (
        .req   (enabled[NUM_SRC-1:0]),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Register file, edge detect and pending bookkeeping.
    always_comb begin
        mask_d     = mask_q;
        gen_d      = gen_q;
        irq_prev_d = irq_req;
        set_bits   = '0;
        clr_bits   = '0;

        set_bits[NUM_SRC-1:0] = irq_req & ~irq_prev_q;

        if (cfg_we) begin
            case (cfg_addr)
                REG_MASK: mask_d   = cfg_wdata & SRC_MASK;
                REG_PEND: clr_bits = cfg_wdata;
                REG_CTRL: gen_d    = cfg_wdata[0];
                default:  ;
            endcase
        end

        if (state_q == ST_ASSERT && ack) begin
            clr_bits = clr_bits | (8'd1 << sel_q);
        end

        // Clear first, then set: a new edge in the same cycle wins.
        pending_d = ((pending_q & ~clr_bits) | set_bits) & SRC_MASK;
    end

    // FSM next state; registered outputs derive from the next state.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        vector_d = vector_q;

        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    sel_d   = enc_idx;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // No withdrawal: only an acknowledge leaves this state.
                if (ack) begin
                    vector_d = VEC_BASE | {4'b0000, sel_q, 1'b0};
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        nint_d      = (state_d != ST_ASSERT);
        vector_oe_d = (state_d == ST_ACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            pending_q   <= '0;
            gen_q       <= 1'b0;
            irq_prev_q  <= '0;
            sel_q       <= '0;
            nint_q      <= 1'b1;
            vector_q    <= '0;
            vector_oe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            gen_q       <= gen_d;
            irq_prev_q  <= irq_prev_d;
            sel_q       <= sel_d;
            nint_q      <= nint_d;
            vector_q    <= vector_d;
            vector_oe_q <= vector_oe_d;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_MASK: cfg_rdata = mask_q;
            REG_PEND: cfg_rdata = pending_q;
            REG_CTRL: cfg_rdata = {7'b0000000, gen_q};
            REG_STAT: cfg_rdata = {(state_q != ST_IDLE), 4'b0000, sel_q};
            default:  cfg_rdata = '0;
        endcase
    end

    assign nint      = nint_q;
    assign vector    = vector_q;
    assign vector_oe = vector_oe_q;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed bench for z80_int_ctrl with immediate-assertion checks.
module tb_z80_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_req;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       nm1;
    logic       niorq;
    logic       nint;
    logic [7:0] vector;
    logic       vector_oe;

    int n_pass = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    z80_int_ctrl #(.NUM_SRC(8), .VEC_BASE(8'hE0)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_req   (irq_req),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .nm1       (nm1),
        .niorq     (niorq),
        .nint      (nint),
        .vector    (vector),
        .vector_oe (vector_oe)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic read_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        cfg_addr = addr;
        #1;
        check(tag, cfg_rdata, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic ack_on();
        nm1   = 1'b0;
        niorq = 1'b0;
    endtask

    task automatic ack_off();
        nm1   = 1'b1;
        niorq = 1'b1;
    endtask

    initial begin
        reset = 1'b1; irq_req = '0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; nm1 = 1'b1; niorq = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_nint", {7'd0, nint}, 8'h01);
        check("rst_oe", {7'd0, vector_oe}, 8'h00);
        check("rst_vector", vector, 8'h00);
        read_chk("rst_mask", 2'd0, 8'h00);
        read_chk("rst_pend", 2'd1, 8'h00);
        read_chk("rst_stat", 2'd3, 8'h00);

        // Basic: source 2
        wr(2'd0, 8'h04);
        wr(2'd2, 8'h01);
        read_chk("basic_ctrl", 2'd2, 8'h01);
        irq_req = 8'h04;
        tick();
        irq_req = 8'h00;
        check("basic_nint_t", {7'd0, nint}, 8'h01);
        read_chk("basic_pend", 2'd1, 8'h04);
        tick();
        check("basic_nint_low", {7'd0, nint}, 8'h00);
        ack_on();
        tick();
        check("basic_vector", vector, 8'hE4);
        check("basic_oe", {7'd0, vector_oe}, 8'h01);
        check("basic_nint_ack", {7'd0, nint}, 8'h01);
        read_chk("basic_pend_clr", 2'd1, 8'h00);
        tick();
        check("basic_oe_hold", {7'd0, vector_oe}, 8'h01);
        ack_off();
        tick();
        check("basic_oe_rel", {7'd0, vector_oe}, 8'h00);
        tick();
        check("basic_nint_idle", {7'd0, nint}, 8'h01);
        read_chk("basic_stat", 2'd3, 8'h02);

        // Priority: sources 5 and 1 together
        wr(2'd0, 8'hFF);
        irq_req = 8'h22;
        tick();
        irq_req = 8'h00;
        read_chk("prio_pend", 2'd1, 8'h22);
        tick();
        check("prio_nint1", {7'd0, nint}, 8'h00);
        read_chk("prio_stat1", 2'd3, 8'h81);
        ack_on();
        tick();
        check("prio_vec1", vector, 8'hE2);
        read_chk("prio_pend1", 2'd1, 8'h20);
        ack_off();
        tick();
        check("prio_gap", {7'd0, nint}, 8'h01);
        tick();
        check("prio_nint2", {7'd0, nint}, 8'h00);
        read_chk("prio_stat2", 2'd3, 8'h85);
        ack_on();
        tick();
        check("prio_vec2", vector, 8'hEA);
        ack_off();
        tick();

        // Masking: source 3 held pending until unmasked
        wr(2'd0, 8'h00);
        irq_req = 8'h08;
        tick();
        irq_req = 8'h00;
        tick();
        check("mask_nint_hi", {7'd0, nint}, 8'h01);
        read_chk("mask_pend", 2'd1, 8'h08);
        wr(2'd0, 8'h08);
        check("mask_nint_wr", {7'd0, nint}, 8'h01);
        tick();
        check("mask_nint_low", {7'd0, nint}, 8'h00);

        // No withdrawal while in ASSERT (sel = 3)
        wr(2'd0, 8'h00);
        check("nowd_mask", {7'd0, nint}, 8'h00);
        wr(2'd1, 8'hFF);
        check("nowd_w1c", {7'd0, nint}, 8'h00);
        read_chk("nowd_pend", 2'd1, 8'h00);
        ack_on();
        tick();
        check("nowd_vector", vector, 8'hE6);
        check("nowd_oe", {7'd0, vector_oe}, 8'h01);
        ack_off();
        tick();
        tick();
        check("nowd_idle", {7'd0, nint}, 8'h01);

        // Set wins over ack clear on source 0
        wr(2'd0, 8'h01);
        irq_req = 8'h01;
        tick();
        irq_req = 8'h00;
        tick();
        check("setw_nint", {7'd0, nint}, 8'h00);
        ack_on();
        irq_req = 8'h01;
        tick();
        check("setw_vector", vector, 8'hE0);
        read_chk("setw_pend", 2'd1, 8'h01);
        irq_req = 8'h00;
        ack_off();
        tick();
        check("setw_oe_rel", {7'd0, vector_oe}, 8'h00);
        tick();
        check("setw_reassert", {7'd0, nint}, 8'h00);
        ack_on();
        tick();
        check("setw_oe2", {7'd0, vector_oe}, 8'h01);

        // Reset while in ACK
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rack_oe", {7'd0, vector_oe}, 8'h00);
        check("rack_nint", {7'd0, nint}, 8'h01);
        check("rack_vector", vector, 8'h00);
        read_chk("rack_mask", 2'd0, 8'h00);
        read_chk("rack_pend", 2'd1, 8'h00);
        read_chk("rack_ctrl", 2'd2, 8'h00);
        read_chk("rack_stat", 2'd3, 8'h00);
        tick();
        check("rack_oe2", {7'd0, vector_oe}, 8'h00);
        ack_off();
        tick();
        check("rack_nint2", {7'd0, nint}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
